pwm_decoder: RTL and testbench

- Receive-side counterpart of the servo PWM generator: measures the high time of an incoming PWM pulse train and converts it back to a Wpos-bit position code.
- Uses the same timing parameters as the generator, so a generator→decoder loopback returns the original position (floor rounding).
- Sits on servo/RC receiver inputs and in loopback self-test.
- Flags glitches and stuck lines, and reports signal presence.

---
 rtl/pwm_decoder_if.sv | 15 +
 rtl/pwm_decoder.sv | 158 +++++++++++++++
 tb/tb_pwm_decoder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pwm_decoder_if.sv
// Signal bundle between a PWM decoder and its user: enable and raw PWM in,
// decoded position plus status strobes out.
interface pwm_decoder_if #(
    parameter int WPOS = 8
);
    logic            ena;
    logic            pwm_in;
    logic [WPOS-1:0] pos;
    logic            valid;
    logic            err;
    logic            present;

    modport slave  (input  ena, pwm_in, output pos, valid, err, present);
    modport master (output ena, pwm_in, input  pos, valid, err, present);
endinterface

// File: rtl/pwm_decoder.sv
// Servo PWM decoder: measures the high time of each pulse and converts it back
// into a WPOS-bit position, with glitch/stuck-line detection and presence.
module pwm_decoder #(
    parameter int TCLK_NS = 20,
    parameter int TDUT_NS = 20_000_000,
    parameter int TMIN_NS = 500_000,
    parameter int TMAX_NS = 2_500_000,
    parameter int WPOS    = 8
) (
    input  logic          clk,
    input  logic          rst_,
    pwm_decoder_if.slave  bus
);
    localparam int NDUT = TDUT_NS / TCLK_NS;
    localparam int NMIN = TMIN_NS / TCLK_NS;
    localparam int M    = (TMAX_NS - TMIN_NS) / (TCLK_NS * (2 ** WPOS));
    localparam int CW   = $clog2(NDUT + 1);
    localparam int PW   = (M > 1) ? $clog2(M) : 1;

    localparam logic [CW-1:0]   NDUT_C  = CW'(NDUT);
    localparam logic [CW-1:0]   NDUT_M1 = CW'(NDUT - 1);
    localparam logic [CW-1:0]   NMIN_C  = CW'(NMIN);
    localparam logic [PW-1:0]   M_M1    = PW'(M - 1);
    localparam logic [WPOS-1:0] POS_MAX = '1;

    typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, CHECK} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   width, width_d;
    logic [CW-1:0]   low, low_d;
    logic [PW-1:0]   presc, presc_d;
    logic [WPOS-1:0] acc, acc_d;
    logic [WPOS-1:0] pos_q, pos_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            present_q, present_d;

    logic s1, s2, s3;
    logic rise, fall;

    // NOTE: the synchronizer is deliberately not reset so that a line already
    // high when reset releases is seen as high, and IDLE discards that pulse.
    always_ff @(posedge clk) begin
        s1 <= bus.pwm_in;
        s2 <= s1;
        s3 <= s2;
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    always_ff @(posedge clk) begin
        if (rst_) begin
            state     <= IDLE;
            width     <= '0;
            low       <= '0;
            presc     <= '0;
            acc       <= '0;
            pos_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            present_q <= 1'b0;
        end else begin
            state     <= state_d;
            width     <= width_d;
            low       <= low_d;
            presc     <= presc_d;
            acc       <= acc_d;
            pos_q     <= pos_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            present_q <= present_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d   = state;
        width_d   = width;
        low_d     = low;
        presc_d   = presc;
        acc_d     = acc;
        pos_d     = pos_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        present_d = present_q;

        unique case (state)
            IDLE: begin
                width_d = '0;
                low_d   = '0;
                presc_d = '0;
                acc_d   = '0;
                if (!s2) state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (rise) begin
                    state_d = HIGH;
                    width_d = CW'(1);
                    presc_d = '0;
                    acc_d   = '0;
                end else if (low != NDUT_C) begin
                    low_d = low + 1'b1;
                    if (low == NDUT_M1) present_d = 1'b0;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_d = CHECK;
                end else if (width == NDUT_M1) begin
                    // line stuck high for a whole frame
                    err_d     = 1'b1;
                    present_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    width_d = width + 1'b1;
                    if (width >= NMIN_C) begin
                        if (presc == M_M1) begin
                            presc_d = '0;
                            if (acc != POS_MAX) acc_d = acc + 1'b1;
                        end else begin
                            presc_d = presc + 1'b1;
                        end
                    end
                end
            end
            CHECK: begin
                state_d = WAIT_RISE;
                low_d   = '0;
                if (width >= NMIN_C) begin
                    pos_d     = acc;
                    valid_d   = 1'b1;
                    present_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!bus.ena) begin
            state_d   = IDLE;
            width_d   = '0;
            low_d     = '0;
            presc_d   = '0;
            acc_d     = '0;
            valid_d   = 1'b0;
            err_d     = 1'b0;
            present_d = 1'b0;
        end
    end

    assign bus.pos     = pos_q;
    assign bus.valid   = valid_q;
    assign bus.err     = err_q;
    assign bus.present = present_q;
endmodule

// File: tb/tb_pwm_decoder.sv
// Scoreboard bench for pwm_decoder using scaled timing (NDUT=2000, NMIN=250,
// M=3) so every scenario fits in a short run.
module tb_pwm_decoder;
    localparam int NDUT = 2000;
    localparam int NMIN = 250;
    localparam int M    = 3;

    typedef struct {
        bit is_err;
        int pos;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   prev_present = 1'b0;

    exp_t exp_q[$];
    int   pres_q[$];

    pwm_decoder_if #(.WPOS(8)) bus ();

    pwm_decoder #(
        .TCLK_NS(20),
        .TDUT_NS(40_000),
        .TMIN_NS(5_000),
        .TMAX_NS(20_600),
        .WPOS   (8)
    ) dut (
        .clk (clk),
        .rst_(rst_),
        .bus (bus.slave)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_unexpected(input string name);
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL %s: event at cycle %0d, none expected", name, cyc);
    endtask

    // Monitor: pops the scoreboard on every strobe and every loss of presence.
    always @(negedge clk) begin
        exp_t e;
        int   pc;
        if (!rst_) begin
            if (bus.valid || bus.err) begin
                if (exp_q.size() == 0) begin
                    fail_unexpected("unexpected_strobe");
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_err",   bus.err,   e.is_err);
                    check("strobe_valid", bus.valid, !e.is_err);
                    check("strobe_pos",   bus.pos,   e.pos);
                    check("strobe_cycle", cyc,       e.cyc);
                    if (bus.valid) check("present_on_valid", bus.present, 1);
                end
            end
            if (prev_present && !bus.present) begin
                if (pres_q.size() == 0) begin
                    fail_unexpected("unexpected_present_drop");
                end else begin
                    pc = pres_q.pop_front();
                    check("present_drop_cycle", cyc, pc);
                end
            end
            prev_present = bus.present;
        end
    end

    // Called on a negedge: high for w cycles, then low for gap cycles.
    task automatic pulse(input int w, input bit is_err, input int epos, input int gap);
        bus.pwm_in = 1'b1;
        repeat (w) @(negedge clk);
        bus.pwm_in = 1'b0;
        exp_q.push_back(exp_t'{is_err, epos, cyc + 4});
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        int a;
        rst_       = 1'b1;
        bus.ena    = 1'b1;
        bus.pwm_in = 1'b1;
        repeat (100) @(negedge clk);
        check("reset_pos",     bus.pos,     0);
        check("reset_valid",   bus.valid,   0);
        check("reset_err",     bus.err,     0);
        check("reset_present", bus.present, 0);
        rst_ = 1'b0;

        // partial pulse left over from reset must be ignored
        repeat (100) @(negedge clk);
        bus.pwm_in = 1'b0;
        repeat (50) @(negedge clk);
        pulse(288, 1'b0, 12, 300);

        // floor boundaries around pos 0/1, then mid scale
        pulse(250, 1'b0, 0, 300);
        pulse(252, 1'b0, 0, 300);
        pulse(253, 1'b0, 1, 300);
        pulse(634, 1'b0, 128, 300);

        // full scale and saturation
        pulse(1015, 1'b0, 255, 300);
        pulse(1018, 1'b0, 255, 300);
        pulse(1100, 1'b0, 255, 300);

        // glitch rejected with pos held, then a good pulse
        pulse(10, 1'b1, 255, 300);
        check("present_after_glitch", bus.present, 1);
        pulse(442, 1'b0, 64, 0);

        // loss of signal: present drops NDUT cycles after the valid strobe
        pres_q.push_back(cyc + 4 + NDUT);
        repeat (NDUT + 100) @(negedge clk);
        check("pos_after_loss",     bus.pos,     64);
        check("present_after_loss", bus.present, 0);

        // stuck high for a whole frame
        pulse(300, 1'b0, 16, 200);
        bus.pwm_in = 1'b1;
        a = cyc;
        exp_q.push_back(exp_t'{1'b1, 16, a + NDUT + 2});
        pres_q.push_back(a + NDUT + 2);
        repeat (NDUT + 50) @(negedge clk);
        bus.pwm_in = 1'b0;
        repeat (200) @(negedge clk);
        check("pos_after_stuck", bus.pos, 16);

        // enable dropped mid-pulse: that pulse is discarded
        pulse(400, 1'b0, 50, 100);
        bus.pwm_in = 1'b1;
        repeat (100) @(negedge clk);
        bus.ena = 1'b0;
        pres_q.push_back(cyc + 1);
        repeat (20) @(negedge clk);
        bus.ena = 1'b1;
        repeat (100) @(negedge clk);
        bus.pwm_in = 1'b0;
        repeat (100) @(negedge clk);
        check("pos_after_ena", bus.pos, 50);
        pulse(500, 1'b0, 83, 100);

        // loopback against generator widths NMIN + pos*M
        for (int p = 0; p < 256; p += 17) pulse(NMIN + p * M, 1'b0, p, 100);

        for (int i = 0; i < 5000 && (exp_q.size() != 0 || pres_q.size() != 0); i++)
            @(negedge clk);
        check("strobe_queue_drained",  exp_q.size(),  0);
        check("present_queue_drained", pres_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
